// File: rtl/dccm_lsu_mem.sv
// dccm_lsu_mem -- data closely-coupled memory for the Buraq core.
//
// Byte-addressed SRAM of Depth words, DataWidth bits each (32 or 64), placed
// between the core memory stage and on-chip storage. Decodes RISC-V load/store
// funct3, writes strobed byte lanes on stores, aligns and sign/zero-extends
// sub-word loads, and reports misaligned or illegal accesses on rsp_err.
//
// Ports:
//   brq_clk     clock, all state updates on the rising edge
//   brq_rst_n   asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V size/sign code
//   req_addr    byte address
//   req_wdata   store data, LSB-justified
//   rsp_valid   response present
//   rsp_ready   consumer accepts the response
//   rsp_rdata   load result, aligned and extended; 0 for stores and errors
//   rsp_err     access was misaligned or had an illegal funct3
//
// Handshake: a request is accepted on a rising edge where req_valid &&
// req_ready; a response is consumed on an edge where rsp_valid && rsp_ready.
// req_ready = !rsp_valid || rsp_ready, so a consumed response can be replaced
// by a new one on the same edge without a bubble. rsp_valid, rsp_rdata and
// rsp_err stay stable until consumed. req_ready is low while in reset.
//
// The FSM state is state_q (IDLE/RESP); rsp_valid is a direct decode of it.

module dccm_lsu_mem #(
  parameter  int DataWidth = 32,
  parameter  int AddrWidth = 15,
  localparam int NumLanes  = DataWidth / 8,
  localparam int OffW      = $clog2(NumLanes),
  localparam int IdxW      = AddrWidth - OffW,
  localparam int Depth     = 2 ** IdxW
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam bit Is64 = (DataWidth == 64);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state_q;

  logic [DataWidth-1:0] mem [Depth];

  logic                 accept;
  logic [OffW-1:0]      off;
  logic [IdxW-1:0]      idx;
  logic [1:0]           size;
  logic                 is_unsigned;
  logic [3:0]           nbytes;
  logic                 illegal;
  logic                 misaligned;
  logic                 err;
  logic [NumLanes-1:0]  strb;
  logic [DataWidth-1:0] byte_mask;
  logic [DataWidth-1:0] wdata_sh;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] rd_sh;
  logic                 sgn;
  logic [DataWidth-1:0] ld_val;

  assign rsp_valid = (state_q == RESP);
  // Gating with brq_rst_n keeps a request presented during reset (or on the
  // release edge) from being accepted or writing memory.
  assign req_ready = brq_rst_n && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign off         = req_addr[OffW-1:0];
  assign idx         = req_addr[AddrWidth-1:OffW];
  assign size        = req_funct3[1:0];
  assign is_unsigned = req_funct3[2];

  always_comb begin
    nbytes = 4'd1;
    case (size)
      2'b00:   nbytes = 4'd1;
      2'b01:   nbytes = 4'd2;
      2'b10:   nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
  end

  // Illegal codes: 111 always; 011 (double) and 110 (lwu) exist only on the
  // 64-bit build; unsigned codes are load-only.
  always_comb begin
    illegal = 1'b0;
    if (req_funct3 == 3'b111)            illegal = 1'b1;
    if (req_funct3 == 3'b011 && !Is64)   illegal = 1'b1;
    if (req_funct3 == 3'b110 && !Is64)   illegal = 1'b1;
    if (is_unsigned && req_we)           illegal = 1'b1;
  end

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err = illegal || misaligned;

  // strb selects the lanes touched by a store; byte_mask keeps the low
  // nbytes of a load after it has been shifted down to bit 0.
  always_comb begin
    strb      = '0;
    byte_mask = '0;
    for (int i = 0; i < NumLanes; i++) begin
      strb[i]             = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
      byte_mask[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
    end
  end

  assign wdata_sh = req_wdata << {off, 3'b000};
  assign rd_word  = mem[idx];
  assign rd_sh    = rd_word >> {off, 3'b000};

  always_comb begin
    sgn = 1'b0;
    case (size)
      2'b00:   sgn = rd_sh[7];
      2'b01:   sgn = rd_sh[15];
      2'b10:   sgn = rd_sh[31];
      default: sgn = rd_sh[DataWidth-1];
    endcase
  end

  assign ld_val = (rd_sh & byte_mask) |
                  ((!is_unsigned && sgn) ? ~byte_mask : '0);

  // Memory is never reset; only legal accepted stores modify it.
  always_ff @(posedge brq_clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (strb[i]) begin
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  // Response FSM. An accept always (re)loads the response, which covers both
  // IDLE->RESP and the no-bubble RESP->RESP replacement.
  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state_q   <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      state_q   <= RESP;
      rsp_err   <= err;
      rsp_rdata <= (err || req_we) ? '0 : ld_val;
    end else if (state_q == RESP && rsp_ready) begin
      state_q   <= IDLE;
    end
  end

endmodule

// File: tb/tb_dccm_lsu_mem.sv
// Testbench for dccm_lsu_mem: a 32-bit and a 64-bit instance share one clock,
// reset and request bus; sel steers req_valid to one of them and muxes its
// outputs back. Expected responses are queued when a request is accepted and
// compared by a negedge monitor when the response is consumed.

module tb_dccm_lsu_mem;

  // ---------------- clock / reset ----------------
  logic brq_clk = 1'b0;
  always #5 brq_clk = ~brq_clk;

  logic        brq_rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [14:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready_32, rsp_valid_32, rsp_err_32;
  logic [31:0] rsp_rdata_32;
  logic        req_ready_64, rsp_valid_64, rsp_err_64;
  logic [63:0] rsp_rdata_64;

  logic        req_ready_m, rsp_valid_m, rsp_err_m;
  logic [63:0] rsp_rdata_m;

  assign req_ready_m = sel ? req_ready_64 : req_ready_32;
  assign rsp_valid_m = sel ? rsp_valid_64 : rsp_valid_32;
  assign rsp_err_m   = sel ? rsp_err_64   : rsp_err_32;
  assign rsp_rdata_m = sel ? rsp_rdata_64 : {32'h0, rsp_rdata_32};

  dccm_lsu_mem #(.DataWidth(32), .AddrWidth(15)) dut32 (
    .brq_clk    (brq_clk),
    .brq_rst_n  (brq_rst_n),
    .req_valid  (req_valid && !sel),
    .req_ready  (req_ready_32),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata[31:0]),
    .rsp_valid  (rsp_valid_32),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata_32),
    .rsp_err    (rsp_err_32)
  );

  dccm_lsu_mem #(.DataWidth(64), .AddrWidth(15)) dut64 (
    .brq_clk    (brq_clk),
    .brq_rst_n  (brq_rst_n),
    .req_valid  (req_valid && sel),
    .req_ready  (req_ready_64),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid_64),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata_64),
    .rsp_err    (rsp_err_64)
  );

  int cyc = 0;
  always @(posedge brq_clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];   // {err, data}
  int          acc_q[$];   // cycle count at the negedge before the accept edge
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        lat_chk = 1'b1;
  int          t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge brq_clk) begin
    logic [64:0] e;
    int          a;
    if (brq_rst_n && rsp_valid_m && rsp_ready) begin
      chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_err", 64'(rsp_err_m), 64'(e[64]));
        chk("rsp_rdata", rsp_rdata_m, e[63:0]);
        if (lat_chk) chk("rsp_latency", 64'(cyc - a), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic we, input logic [2:0] f3, input logic [14:0] addr,
                      input logic [63:0] wd, input logic e_err, input logic [63:0] e_data,
                      output int acc);
    int n;
    n          = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge brq_clk);
    while (!req_ready_m && n < 50) begin
      @(negedge brq_clk);
      n++;
    end
    chk("req_accept", 64'(req_ready_m), 64'd1);
    exp_q.push_back({e_err, e_data});
    acc_q.push_back(cyc);
    acc = cyc;
    @(posedge brq_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge brq_clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge brq_clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, a1;
    brq_rst_n  = 1'b0;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;

    repeat (2) @(negedge brq_clk);
    chk("reset_rsp_valid_32", 64'(rsp_valid_32), 64'd0);
    chk("reset_rsp_rdata_32", 64'(rsp_rdata_32), 64'd0);
    chk("reset_rsp_err_32",   64'(rsp_err_32),   64'd0);
    chk("reset_req_ready_32", 64'(req_ready_32), 64'd0);
    chk("reset_rsp_valid_64", 64'(rsp_valid_64), 64'd0);
    chk("reset_rsp_rdata_64", rsp_rdata_64,      64'd0);
    chk("reset_req_ready_64", 64'(req_ready_64), 64'd0);
    @(posedge brq_clk);
    #1;
    brq_rst_n = 1'b1;
    @(posedge brq_clk);
    #1;

    // 32-bit: word store then sub-word loads with sign/zero extension
    send(1'b1, 3'b010, 15'h10, 64'hDEADBEEF, 1'b0, 64'h0, t);
    send(1'b0, 3'b000, 15'h13, 64'h0, 1'b0, 64'hFFFFFFDE, t);
    send(1'b0, 3'b100, 15'h13, 64'h0, 1'b0, 64'h000000DE, t);
    send(1'b0, 3'b001, 15'h12, 64'h0, 1'b0, 64'hFFFFDEAD, t);
    send(1'b0, 3'b101, 15'h12, 64'h0, 1'b0, 64'h0000DEAD, t);
    send(1'b0, 3'b010, 15'h10, 64'h0, 1'b0, 64'hDEADBEEF, t);

    // byte store then back-to-back word load (read-after-write, no stall)
    send(1'b1, 3'b000, 15'h11, 64'h5A, 1'b0, 64'h0, a0);
    send(1'b0, 3'b010, 15'h10, 64'h0, 1'b0, 64'hDEAD5AEF, a1);
    chk("b2b_no_stall", 64'(a1 - a0), 64'd1);

    // misaligned / illegal accesses; memory must be untouched
    send(1'b1, 3'b010, 15'h04, 64'h11223344, 1'b0, 64'h0, t);
    send(1'b0, 3'b001, 15'h01, 64'h0, 1'b1, 64'h0, t);
    send(1'b0, 3'b010, 15'h02, 64'h0, 1'b1, 64'h0, t);
    send(1'b1, 3'b010, 15'h06, 64'hFFFFFFFF, 1'b1, 64'h0, t);
    send(1'b1, 3'b100, 15'h04, 64'hFFFFFFFF, 1'b1, 64'h0, t);
    send(1'b0, 3'b111, 15'h04, 64'h0, 1'b1, 64'h0, t);
    send(1'b0, 3'b011, 15'h08, 64'h0, 1'b1, 64'h0, t);
    send(1'b0, 3'b110, 15'h04, 64'h0, 1'b1, 64'h0, t);
    send(1'b0, 3'b010, 15'h04, 64'h0, 1'b0, 64'h11223344, t);
    send(1'b0, 3'b001, 15'h04, 64'h0, 1'b0, 64'h00003344, t);
    drain();

    // backpressure: response held, second request stalled, then dual handshake
    lat_chk   = 1'b0;
    rsp_ready = 1'b0;
    send(1'b0, 3'b010, 15'h10, 64'h0, 1'b0, 64'hDEAD5AEF, t);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 15'h04;
    req_wdata  = '0;
    repeat (3) begin
      @(negedge brq_clk);
      chk("bp_rsp_valid", 64'(rsp_valid_m), 64'd1);
      chk("bp_rsp_rdata", rsp_rdata_m, 64'hDEAD5AEF);
      chk("bp_req_ready", 64'(req_ready_m), 64'd0);
      @(posedge brq_clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge brq_clk);
    chk("bp_req_ready_release", 64'(req_ready_m), 64'd1);
    exp_q.push_back({1'b0, 64'h11223344});
    acc_q.push_back(cyc);
    @(posedge brq_clk);
    #1;
    req_valid = 1'b0;
    @(negedge brq_clk);
    chk("bp_next_rsp_valid", 64'(rsp_valid_m), 64'd1);
    @(posedge brq_clk);
    #1;
    lat_chk = 1'b1;
    drain();

    // 64-bit build
    sel = 1'b1;
    send(1'b1, 3'b011, 15'h08, 64'h0123456789ABCDEF, 1'b0, 64'h0, t);
    send(1'b0, 3'b110, 15'h0C, 64'h0, 1'b0, 64'h0000000001234567, t);
    send(1'b0, 3'b010, 15'h0C, 64'h0, 1'b0, 64'h0000000001234567, t);
    send(1'b0, 3'b011, 15'h08, 64'h0, 1'b0, 64'h0123456789ABCDEF, t);
    send(1'b0, 3'b010, 15'h08, 64'h0, 1'b0, 64'hFFFFFFFF89ABCDEF, t);
    send(1'b0, 3'b000, 15'h08, 64'h0, 1'b0, 64'hFFFFFFFFFFFFFFEF, t);
    send(1'b0, 3'b000, 15'h0F, 64'h0, 1'b0, 64'h0000000000000001, t);
    send(1'b0, 3'b011, 15'h0C, 64'h0, 1'b1, 64'h0, t);
    send(1'b1, 3'b110, 15'h08, 64'h0, 1'b1, 64'h0, t);
    send(1'b0, 3'b011, 15'h08, 64'h0, 1'b0, 64'h0123456789ABCDEF, t);
    drain();

    // reset while a response is outstanding
    sel       = 1'b0;
    rsp_ready = 1'b0;
    send(1'b0, 3'b010, 15'h10, 64'h0, 1'b0, 64'hDEAD5AEF, t);
    @(negedge brq_clk);
    chk("pre_reset_rsp_valid", 64'(rsp_valid_m), 64'd1);
    #2;
    brq_rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", 64'(rsp_valid_m), 64'd0);
    chk("async_reset_rsp_rdata", rsp_rdata_m, 64'd0);
    chk("async_reset_rsp_err",   64'(rsp_err_m), 64'd0);
    exp_q.delete();
    acc_q.delete();
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 15'h10;
    req_wdata  = 64'hFFFFFFFF;
    @(negedge brq_clk);
    chk("reset_req_ready_gated", 64'(req_ready_m), 64'd0);
    repeat (2) @(posedge brq_clk);
    #1;
    req_valid = 1'b0;
    #2;
    brq_rst_n = 1'b1;
    @(negedge brq_clk);
    chk("post_reset_idle", 64'(rsp_valid_m), 64'd0);
    @(posedge brq_clk);
    #1;
    send(1'b0, 3'b010, 15'h10, 64'h0, 1'b0, 64'hDEAD5AEF, t);
    send(1'b0, 3'b010, 15'h04, 64'h0, 1'b0, 64'h11223344, t);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dccm_lsu_mem.md
Name: dccm_lsu_mem

Overview:
- Next-generation data closely-coupled memory for the Buraq core.
- Width-parametrised (32/64-bit), byte-addressed, with per-lane write strobes and a valid/ready request/response handshake.
- Registered read with 1-cycle latency; holds the response under backpressure.
- Decodes RISC-V load/store funct3, aligns and sign/zero-extends sub-word loads, and flags misaligned or illegal accesses.
- Sits between the core's memory stage and on-chip SRAM.

Parameters:
- DataWidth, 32, word width in bits; legal values 32 or 64.
- AddrWidth, 15, byte-address width.
- NumLanes, DataWidth/8, derived; byte lanes per word.
- Depth, 2**(AddrWidth-log2(NumLanes)), derived; number of words.

Ports:
- brq_clk  input  1  clock; all state updates on rising edge.
- brq_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V size/sign code.
- req_addr  input  AddrWidth  byte address.
- req_wdata  input  DataWidth  store data, LSB-justified.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DataWidth  load result, aligned and extended; 0 for stores and errors.
- rsp_err  output  1  access was misaligned or had an illegal funct3.

Behaviour:
- Interface decision: one clock, brq_clk; reset brq_rst_n is asynchronous and active-low.
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory contents are not cleared.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - A request is accepted on an edge where req_valid && req_ready.
  - The response appears the following cycle: rsp_valid=1.
  - rsp_valid/rsp_rdata/rsp_err hold stable until rsp_valid && rsp_ready.
  - At most one response is outstanding.
- State machine: two states, IDLE (rsp_valid=0) and RESP (rsp_valid=1).
  - IDLE -> RESP on accept.
  - RESP -> IDLE on rsp_ready with no new accept.
  - RESP -> RESP when rsp_ready and a new request are accepted in the same cycle; the response is replaced, with no bubble.
- funct3 decode:
  - 000 byte signed (lb/sb), 001 half signed (lh/sh), 010 word signed (lw/sw).
  - 011 double (ld/sd): legal only when DataWidth=64.
  - 100 byte unsigned (lbu), 101 half unsigned (lhu), 110 word unsigned (lwu): 110 legal only when DataWidth=64, load only.
  - 111 always illegal. Any unsigned code with req_we=1 is illegal.
- Alignment:
  - The access size must divide the address low bits (half: addr[0]=0; word: addr[1:0]=0; double: addr[2:0]=0).
  - Violation or illegal code: rsp_err=1, rsp_rdata=0, no memory write.
- Stores:
  - Word index = addr[AddrWidth-1:log2(NumLanes)].
  - Lane offset = addr low bits.
  - Write strobes cover size bytes starting at the offset.
  - Strobed lanes take req_wdata bytes shifted to the offset.
  - Non-strobed lanes are unchanged.
  - The write occurs on the accept edge.
  - Store response: rsp_err=0, rsp_rdata=0.
- Loads:
  - Memory is read at accept.
  - The selected bytes are shifted down to bit 0.
  - Signed codes sign-extend from the top selected bit to DataWidth; unsigned codes zero-extend.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated bytes.
- Reset mid-operation:
  - An outstanding response is discarded.
  - A request presented on the reset-release edge is not accepted (req_ready is gated low while brq_rst_n=0).
  - No memory write occurs while in reset.
- Address wrap: none; every AddrWidth address maps to a unique byte.

Test Plan:
- DataWidth=32, rsp_ready=1, sw 0xDEADBEEF @0x10; then lb @0x13, lbu @0x13, lh @0x12, lhu @0x12, lw @0x10:
  - responses 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
  - Each response arrives 1 cycle after accept, rsp_err=0.
- sb 0x5A @0x11 over 0xDEADBEEF, then lw @0x10 back-to-back -> 0xDEAD5AEF, with no stall between the two requests.
- Misaligned accesses: lh @0x01, lw @0x02, sw @0x06 -> rsp_err=1, rsp_rdata=0; a following lw @0x04 shows the prior contents unchanged.
- Backpressure:
  - Issue lw with rsp_ready=0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, the second request is not accepted.
  - Raise rsp_ready with req_valid=1 -> both handshakes in one cycle, and the next response follows immediately.
- DataWidth=64: sd 0x0123456789ABCDEF @0x8; lwu @0xC -> 0x0000000001234567; lw @0xC -> 0x0000000001234567; ld @0x8 -> full value. funct3=011 on a 32-bit build -> rsp_err=1.
- Assert brq_rst_n=0 while rsp_valid=1 -> rsp_valid, rsp_rdata, rsp_err reach 0 asynchronously. After release, lw of a previously written address returns the pre-reset data.
